// File: rtl/sd_card_pkg.sv
// Shared types and constants for the SD-card SPI write path (CMD24 data phase).
package sd_card_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TOK,
        ST_DATA,
        ST_CRC,
        ST_RESP,
        ST_BUSY,
        ST_DONE
    } wr_state_t;

    localparam logic [7:0]  TOKEN_START = 8'hFE;
    localparam logic [7:0]  TOKEN_IDLE  = 8'hFF;
    localparam logic [7:0]  DRESP_OK    = 8'h05;
    localparam logic [7:0]  DRESP_CRC   = 8'h0B;
    localparam logic [15:0] CRC16_POLY  = 16'h1021;

    // CRC16-CCITT, MSB first, one full byte per call.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_crc16.sv
// Byte-serial CRC16-CCITT accumulator: one data byte folded in per enabled clock.
module sd_crc16
    import sd_card_pkg::*;
(
    input  logic        clk,
    input  logic        io_rd_reset,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    always_ff @(posedge clk or posedge io_rd_reset) begin
        if (io_rd_reset)  crc <= '0;
        else if (clear)   crc <= '0;
        else if (en)      crc <= crc16_byte(crc, data);
    end

endmodule

// File: rtl/sd_card_wr.sv
// SD-card SPI write path: buffers one CMD24 sector, sends the data-response token,
// holds MISO busy while the io controller drains the sector. SD_WR_CRC_EN enables CRC check.
module sd_card_wr
    import sd_card_pkg::*;
#(
    parameter int BLOCK_BYTES = 512,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        io_rd_reset,
    input  logic        wr_start,
    input  logic [31:0] wr_lba,
    input  logic        sd_cs,
    input  logic        sd_sck,
    input  logic        sd_sdi,
    output logic        sd_sdo_wr,
    output logic        sd_sdo_en,
    output logic        io_wr,
    output logic [31:0] io_lba,
    input  logic        io_ack,
    input  logic        io_dout_strobe,
    output logic [7:0]  io_dout
);

    localparam int               PTR_W    = $clog2(BLOCK_BYTES);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BLOCK_BYTES - 1);
    // Synchronizer bundle order {sdi, cs, sck, ack, strobe}; idle bus levels at reset.
    localparam logic [4:0]       SYNC_RST = 5'b11000;

    logic [4:0]       sync_q [SYNC_STAGES];
    logic [4:0]       sync_s;
    logic [2:0]       sync_d;
    logic             sdi_s, cs_s, sck_s, ack_s;
    logic             sck_rise, sck_fall, ack_fall, stb_fall;
    logic [6:0]       shift_q;
    logic [2:0]       bit_cnt;
    logic             byte_done;
    logic [7:0]       byte_val;
    wr_state_t        state_q, state_d;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             crc_cnt;
    logic [7:0]       tx_q;
    logic [3:0]       tx_cnt;
    logic             sdo_q;
    logic             ack_seen;
    logic             mem_we, enter_resp;
    logic             resp_bad_now, crc_bad_q;
    logic [7:0]       mem [BLOCK_BYTES];

    always_ff @(posedge clk or posedge io_rd_reset) begin
        if (io_rd_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
            sync_d <= SYNC_RST[2:0];
        end else begin
            sync_q[0] <= {sd_sdi, sd_cs, sd_sck, io_ack, io_dout_strobe};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sync_d <= sync_s[2:0];
        end
    end

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign sdi_s    = sync_s[4];
    assign cs_s     = sync_s[3];
    assign sck_s    = sync_s[2];
    assign ack_s    = sync_s[1];
    assign sck_rise = sck_s & ~sync_d[2] & ~cs_s;
    assign sck_fall = ~sck_s & sync_d[2] & ~cs_s;
    assign ack_fall = ~ack_s & sync_d[1];
    assign stb_fall = ~sync_s[0] & sync_d[0];

    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign byte_val  = {shift_q, sdi_s};

    always_ff @(posedge clk or posedge io_rd_reset) begin
        if (io_rd_reset) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (cs_s || (state_q == ST_IDLE && wr_start)) begin
            bit_cnt <= '0;
        end else if (sck_rise) begin
            shift_q <= {shift_q[5:0], sdi_s};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge io_rd_reset) begin
        if (io_rd_reset) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (wr_start) state_d = ST_WAIT_TOK;
            ST_WAIT_TOK: begin
                if (cs_s) state_d = ST_IDLE;
                else if (byte_done && byte_val == TOKEN_START) state_d = ST_DATA;
                else if (byte_done && byte_val != TOKEN_IDLE)  state_d = ST_IDLE;
            end
            ST_DATA: begin
                if (cs_s) state_d = ST_IDLE;
                else if (byte_done && wr_ptr == LAST_PTR) state_d = ST_CRC;
            end
            ST_CRC: begin
                if (cs_s) state_d = ST_IDLE;
                else if (byte_done && crc_cnt) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (cs_s) state_d = ST_IDLE;
                else if (sck_fall && tx_cnt == 4'd8) state_d = crc_bad_q ? ST_IDLE : ST_BUSY;
            end
            ST_BUSY:     if (ack_fall) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sd_sdo_wr = 1'b1;
        sd_sdo_en = 1'b0;
        case (state_q)
            ST_RESP: begin
                sd_sdo_wr = sdo_q;
                sd_sdo_en = 1'b1;
            end
            ST_BUSY: begin
                sd_sdo_wr = 1'b0;
                sd_sdo_en = ~cs_s;
            end
            default: ;
        endcase
    end

    assign mem_we     = (state_q == ST_DATA) && byte_done;
    assign enter_resp = (state_q == ST_CRC) && (state_d == ST_RESP);

    always_ff @(posedge clk or posedge io_rd_reset) begin
        if (io_rd_reset) begin
            io_lba  <= '0;
            wr_ptr  <= '0;
            crc_cnt <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && wr_start) begin
                io_lba  <= wr_lba;
                wr_ptr  <= '0;
                crc_cnt <= 1'b0;
            end
            if (mem_we) wr_ptr <= wr_ptr + 1'b1;
            if (state_q == ST_CRC && byte_done) crc_cnt <= ~crc_cnt;
        end
    end

    // Response token: MSB leaves on the first sck fall in RESP, the ninth fall ends the byte.
    always_ff @(posedge clk or posedge io_rd_reset) begin
        if (io_rd_reset) begin
            tx_q   <= '1;
            tx_cnt <= '0;
            sdo_q  <= 1'b1;
        end else if (enter_resp) begin
            tx_q   <= resp_bad_now ? DRESP_CRC : DRESP_OK;
            tx_cnt <= '0;
            sdo_q  <= 1'b1;
        end else if (state_q == ST_RESP && sck_fall && tx_cnt != 4'd8) begin
            sdo_q  <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b1};
            tx_cnt <= tx_cnt + 4'd1;
        end
    end

    // io_wr is the sector-valid flag; io_ack high is the controller accepting it and
    // holding the transfer, so io_wr drops on first ack and stays low for this sector.
    always_ff @(posedge clk or posedge io_rd_reset) begin
        if (io_rd_reset) begin
            io_wr    <= 1'b0;
            ack_seen <= 1'b0;
            rd_ptr   <= '0;
        end else if (state_q == ST_BUSY) begin
            if (ack_s) begin
                io_wr    <= 1'b0;
                ack_seen <= 1'b1;
            end else if (!ack_seen) begin
                io_wr <= 1'b1;
            end
            if (stb_fall) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        end else begin
            io_wr    <= 1'b0;
            ack_seen <= 1'b0;
            if (state_q == ST_DONE) rd_ptr <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr] <= byte_val;
    end

    assign io_dout = mem[rd_ptr];

`ifdef SD_WR_CRC_EN
    logic [15:0] crc_calc;
    logic [7:0]  crc_hi_q;

    sd_crc16 u_crc (
        .clk         (clk),
        .io_rd_reset (io_rd_reset),
        .clear       (state_q == ST_IDLE && wr_start),
        .en          (mem_we),
        .data        (byte_val),
        .crc         (crc_calc)
    );

    assign resp_bad_now = ({crc_hi_q, byte_val} != crc_calc);

    always_ff @(posedge clk or posedge io_rd_reset) begin
        if (io_rd_reset) begin
            crc_hi_q  <= '0;
            crc_bad_q <= 1'b0;
        end else begin
            if (state_q == ST_CRC && byte_done && !crc_cnt) crc_hi_q <= byte_val;
            if (enter_resp) crc_bad_q <= resp_bad_now;
        end
    end
`else
    assign resp_bad_now = 1'b0;
    assign crc_bad_q    = 1'b0;
`endif

endmodule

// File: tb/tb_sd_card_wr.sv
// Directed bench for sd_card_wr: SPI host and io controller drivers, expected-byte scoreboard.
module tb_sd_card_wr;

    localparam int BB = 64;

    logic        clk = 1'b0;
    logic        io_rd_reset = 1'b1;
    logic        wr_start = 1'b0;
    logic [31:0] wr_lba = '0;
    logic        sd_cs = 1'b1;
    logic        sd_sck = 1'b0;
    logic        sd_sdi = 1'b1;
    logic        io_ack = 1'b0;
    logic        io_dout_strobe = 1'b0;
    logic        sd_sdo_wr, sd_sdo_en, io_wr;
    logic [31:0] io_lba;
    logic [7:0]  io_dout;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx;
    logic [7:0]  first_b;

    sd_card_wr #(.BLOCK_BYTES(BB), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .io_rd_reset    (io_rd_reset),
        .wr_start       (wr_start),
        .wr_lba         (wr_lba),
        .sd_cs          (sd_cs),
        .sd_sck         (sd_sck),
        .sd_sdi         (sd_sdi),
        .sd_sdo_wr      (sd_sdo_wr),
        .sd_sdo_en      (sd_sdo_en),
        .io_wr          (io_wr),
        .io_lba         (io_lba),
        .io_ack         (io_ack),
        .io_dout_strobe (io_dout_strobe),
        .io_dout        (io_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in ^ {d, 8'h00};
        for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    // Mode 0 host: drive on sck low, DUT samples on rise; MISO sampled just before rise.
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rxb);
        for (int b = 7; b >= 0; b--) begin
            sd_sck = 1'b0;
            sd_sdi = tx[b];
            repeat (4) @(negedge clk);
            rxb[b] = sd_sdo_wr;
            sd_sck = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic spi_send(input logic [7:0] tx);
        logic [7:0] dummy;
        spi_byte(tx, dummy);
    endtask

    task automatic start_write(input logic [31:0] lba);
        @(negedge clk);
        wr_lba   = lba;
        wr_start = 1'b1;
        @(negedge clk);
        wr_start = 1'b0;
    endtask

    // mode: 0 incrementing, 1 random, 2 all-zero
    task automatic do_write(input logic [31:0] lba, input int mode, input bit push,
                            input bit force_crc, input logic [15:0] crc_force);
        logic [15:0] crc;
        logic [7:0]  d;
        crc = '0;
        start_write(lba);
        spi_send(8'hFF);
        spi_send(8'hFE);
        for (int i = 0; i < BB; i++) begin
            d = (mode == 0) ? 8'(i) : (mode == 1) ? 8'($urandom_range(0, 255)) : 8'h00;
            crc = crc_model(crc, d);
            if (push) exp_q.push_back(d);
            spi_send(d);
        end
        if (force_crc) crc = crc_force;
        spi_send(crc[15:8]);
        spi_send(crc[7:0]);
    endtask

    task automatic read_resp(input string tag, input logic [7:0] tok);
        logic [7:0] r;
        spi_byte(8'hFF, r);
        check(tag, {27'd0, r[4:0]}, {27'd0, tok[4:0]});
    endtask

    task automatic drain(input logic exp_en);
        logic [7:0] e;
        io_ack = 1'b1;
        repeat (6) @(negedge clk);
        check("io_wr_clear", io_wr, 1'b0);
        check("busy_en", sd_sdo_en, exp_en);
        check("busy_sdo", sd_sdo_wr, 1'b0);
        for (int i = 0; i < BB; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check("io_dout", io_dout, e);
            io_dout_strobe = 1'b1;
            repeat (3) @(negedge clk);
            io_dout_strobe = 1'b0;
            repeat (5) @(negedge clk);
        end
        io_ack = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic full_write(input logic [31:0] lba, input int mode);
        logic [7:0] r;
        logic [7:0] b0;
        do_write(lba, mode, 1'b1, 1'b0, 16'h0000);
        b0 = exp_q[0];
        read_resp("resp_ok", 8'h05);
        spi_byte(8'hFF, r);
        check("busy_miso", r, 8'h00);
        check("busy_en_pre", sd_sdo_en, 1'b1);
        check("io_wr_set", io_wr, 1'b1);
        check("io_lba", io_lba, lba);
        drain(1'b1);
        check("done_en", sd_sdo_en, 1'b0);
        check("done_sdo", sd_sdo_wr, 1'b1);
        check("rd_ptr_zero", io_dout, b0);
        spi_byte(8'hFF, r);
        check("idle_miso", r, 8'hFF);
    endtask

    initial begin
        // Reset values
        repeat (4) @(negedge clk);
        check("rst_sdo", sd_sdo_wr, 1'b1);
        check("rst_en", sd_sdo_en, 1'b0);
        check("rst_io_wr", io_wr, 1'b0);
        check("rst_lba", io_lba, 32'd0);
        io_rd_reset = 1'b0;
        sd_cs = 1'b0;
        repeat (6) @(negedge clk);

        // 1: normal write, incrementing data
        full_write(32'h12, 0);

        // 2: bad start token after idle bytes
        start_write(32'h77);
        spi_send(8'hFF);
        spi_send(8'hFF);
        spi_send(8'h3C);
        spi_byte(8'hFE, rx);
        check("badtok_miso", rx, 8'hFF);
        for (int i = 0; i < 3; i++) spi_send(8'(i + 1));
        spi_byte(8'hFF, rx);
        check("badtok_miso2", rx, 8'hFF);
        check("badtok_en", sd_sdo_en, 1'b0);
        check("badtok_io_wr", io_wr, 1'b0);

        // 4: cs raised during BUSY; transfer still completes
        do_write(32'h2468, 1, 1'b1, 1'b0, 16'h0000);
        first_b = exp_q[0];
        read_resp("t4_resp", 8'h05);
        spi_byte(8'hFF, rx);
        check("t4_busy", rx, 8'h00);
        sd_cs = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_cs_en", sd_sdo_en, 1'b0);
        sd_cs = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_recs_en", sd_sdo_en, 1'b1);
        check("t4_recs_sdo", sd_sdo_wr, 1'b0);
        spi_byte(8'hFF, rx);
        check("t4_recs_miso", rx, 8'h00);
        sd_cs = 1'b1;
        repeat (6) @(negedge clk);
        drain(1'b0);
        check("t4_done_en", sd_sdo_en, 1'b0);
        check("t4_done_sdo", sd_sdo_wr, 1'b1);
        check("t4_rd_ptr", io_dout, first_b);
        sd_cs = 1'b0;
        repeat (6) @(negedge clk);

        // 3: cs abort mid-DATA, then a full random write
        start_write(32'h33);
        spi_send(8'hFF);
        spi_send(8'hFE);
        for (int i = 0; i < 40; i++) spi_send(8'($urandom_range(0, 255)));
        sd_cs = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_en", sd_sdo_en, 1'b0);
        check("abort_sdo", sd_sdo_wr, 1'b1);
        check("abort_io_wr", io_wr, 1'b0);
        sd_cs = 1'b0;
        repeat (6) @(negedge clk);
        spi_byte(8'hFF, rx);
        check("abort_miso", rx, 8'hFF);
        check("abort_io_wr2", io_wr, 1'b0);
        full_write(32'h44, 1);

`ifdef SD_WR_CRC_EN
        // 5: CRC check, good zero CRC then corrupted CRC
        full_write(32'h55, 2);
        do_write(32'h56, 2, 1'b0, 1'b1, 16'h1234);
        read_resp("crc_bad_resp", 8'h0B);
        spi_byte(8'hFF, rx);
        check("crc_bad_miso", rx, 8'hFF);
        check("crc_bad_en", sd_sdo_en, 1'b0);
        check("crc_bad_io_wr", io_wr, 1'b0);
`endif

        // 6: async reset mid-DATA
        start_write(32'hABCD);
        spi_send(8'hFF);
        spi_send(8'hFE);
        for (int i = 0; i < 10; i++) spi_send(8'(i * 7));
        io_rd_reset = 1'b1;
        #1;
        check("arst_sdo", sd_sdo_wr, 1'b1);
        check("arst_en", sd_sdo_en, 1'b0);
        check("arst_io_wr", io_wr, 1'b0);
        check("arst_lba", io_lba, 32'd0);
        repeat (3) @(negedge clk);
        io_rd_reset = 1'b0;
        repeat (6) @(negedge clk);
        full_write(32'h5A5A, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
